// File: rtl/axi4_mem_slave_if.sv
// AXI4 (AXI3-style HP signalling) bus bundle between a burst master and axi4_mem_slave.
// Carries the AW, W, B, AR and R channels; the master/slave modports give each side's directions.
interface axi4_mem_slave_if #(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_LEN_WIDTH  = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64
);
    logic [AXI_ID_WIDTH-1:0]     axi_awid;
    logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr;
    logic [AXI_LEN_WIDTH-1:0]    axi_awlen;
    logic [2:0]                  axi_awsize;
    logic [1:0]                  axi_awburst;
    logic [1:0]                  axi_awlock;
    logic [3:0]                  axi_awcache;
    logic [2:0]                  axi_awprot;
    logic [3:0]                  axi_awqos;
    logic                        axi_awvalid;
    logic                        axi_awready;

    logic [AXI_ID_WIDTH-1:0]     axi_wid;
    logic [AXI_DATA_WIDTH-1:0]   axi_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb;
    logic                        axi_wlast;
    logic                        axi_wvalid;
    logic                        axi_wready;

    logic [AXI_ID_WIDTH-1:0]     axi_bid;
    logic [1:0]                  axi_bresp;
    logic                        axi_bvalid;
    logic                        axi_bready;

    logic [AXI_ID_WIDTH-1:0]     axi_arid;
    logic [AXI_ADDR_WIDTH-1:0]   axi_araddr;
    logic [AXI_LEN_WIDTH-1:0]    axi_arlen;
    logic [2:0]                  axi_arsize;
    logic [1:0]                  axi_arburst;
    logic [1:0]                  axi_arlock;
    logic [3:0]                  axi_arcache;
    logic [2:0]                  axi_arprot;
    logic [3:0]                  axi_arqos;
    logic                        axi_arvalid;
    logic                        axi_arready;

    logic [AXI_ID_WIDTH-1:0]     axi_rid;
    logic [AXI_DATA_WIDTH-1:0]   axi_rdata;
    logic [1:0]                  axi_rresp;
    logic                        axi_rlast;
    logic                        axi_rvalid;
    logic                        axi_rready;

    modport slave (
        input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
        input  axi_awlock, axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
        output axi_awready,
        input  axi_wid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bid, axi_bresp, axi_bvalid,
        input  axi_bready,
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
        input  axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arvalid,
        output axi_arready,
        output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        input  axi_rready
    );

    modport master (
        output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
        output axi_awlock, axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
        input  axi_awready,
        output axi_wid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_bvalid,
        output axi_bready,
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
        output axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arvalid,
        input  axi_arready,
        input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        output axi_rready
    );
endinterface

// File: rtl/axi4_mem_slave.sv
// AXI4 INCR burst responder backed by a read-first dual-port RAM; independent write and read FSMs.
// Ports: clk, rst_n (async active-low), axi (axi4_mem_slave_if.slave: AW/W/B/AR/R channels).
module axi4_mem_slave #(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_LEN_WIDTH  = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int MEM_AWIDTH     = 10
) (
    input logic             clk,
    input logic             rst_n,
    axi4_mem_slave_if.slave axi
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int HI_LSB = OFF + MEM_AWIDTH;
    localparam int DEPTH  = 2 ** MEM_AWIDTH;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    // ---------------- write channel ----------------
    w_state_t                  w_state, w_next;
    logic [AXI_ID_WIDTH-1:0]   w_id;
    logic [MEM_AWIDTH-1:0]     w_idx;
    logic [AXI_LEN_WIDTH-1:0]  w_len, w_cnt;
    logic                      w_err;
    logic [1:0]                w_resp;
    logic                      awready_q, wready_q, bvalid_q;
    logic                      aw_hs, w_hs, b_hs, w_cnt_last, w_end;
    logic                      mem_we;

    assign aw_hs      = axi.axi_awvalid & awready_q;
    assign w_hs       = axi.axi_wvalid & wready_q;
    assign b_hs       = bvalid_q & axi.axi_bready;
    assign w_cnt_last = (w_cnt == w_len);
    assign w_end      = w_hs & (axi.axi_wlast | w_cnt_last);
    assign mem_we     = w_hs & ~w_err;

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_end) w_next = W_RESP;
            W_RESP:  if (b_hs)  w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            w_id      <= '0;
            w_idx     <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_err     <= 1'b0;
            w_resp    <= RESP_OKAY;
        end else begin
            w_state   <= w_next;
            // awready only after a full cycle back in idle
            awready_q <= (w_state == W_IDLE) && (w_next == W_IDLE);
            wready_q  <= (w_next == W_DATA);
            bvalid_q  <= (w_next == W_RESP);
            if (aw_hs) begin
                w_id  <= axi.axi_awid;
                w_idx <= axi.axi_awaddr[OFF +: MEM_AWIDTH];
                w_len <= axi.axi_awlen;
                w_cnt <= '0;
                w_err <= |axi.axi_awaddr[AXI_ADDR_WIDTH-1:HI_LSB];
            end
            if (w_hs) begin
                w_idx <= w_idx + 1'b1;
                w_cnt <= w_cnt + 1'b1;
            end
            if (w_end) begin
                if (w_err)
                    w_resp <= RESP_DECERR;
                else if (axi.axi_wlast != w_cnt_last)
                    w_resp <= RESP_SLVERR;
                else
                    w_resp <= RESP_OKAY;
            end
        end
    end

    assign axi.axi_awready = awready_q;
    assign axi.axi_wready  = wready_q;
    assign axi.axi_bvalid  = bvalid_q;
    assign axi.axi_bid     = w_id;
    assign axi.axi_bresp   = w_resp;

    // ---------------- read channel ----------------
    r_state_t                  r_state, r_next;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [MEM_AWIDTH-1:0]     r_idx;
    logic [AXI_LEN_WIDTH-1:0]  r_len, r_cnt;
    logic                      r_err;
    logic                      arready_q, rvalid_q;
    logic                      ar_hs, r_hs, r_last, rd_en;
    logic [AXI_DATA_WIDTH-1:0] rd_word;

    assign ar_hs  = axi.axi_arvalid & arready_q;
    assign r_hs   = rvalid_q & axi.axi_rready;
    assign r_last = (r_cnt == r_len);
    // r_idx always points at the word after the one on the bus,
    // so each accepted beat prefetches the next one
    assign rd_en  = (r_state == R_FETCH) | r_hs;

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_FETCH;
            R_FETCH: r_next = R_DATA;
            R_DATA:  if (r_hs && r_last) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            r_id      <= '0;
            r_idx     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= r_next;
            arready_q <= (r_next == R_IDLE);
            rvalid_q  <= (r_next == R_DATA);
            if (ar_hs) begin
                r_id  <= axi.axi_arid;
                r_idx <= axi.axi_araddr[OFF +: MEM_AWIDTH];
                r_len <= axi.axi_arlen;
                r_cnt <= '0;
                r_err <= |axi.axi_araddr[AXI_ADDR_WIDTH-1:HI_LSB];
            end
            if (rd_en)
                r_idx <= r_idx + 1'b1;
            if (r_hs)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign axi.axi_arready = arready_q;
    assign axi.axi_rvalid  = rvalid_q;
    assign axi.axi_rid     = r_id;
    assign axi.axi_rdata   = (rvalid_q && !r_err) ? rd_word : '0;
    assign axi.axi_rresp   = (rvalid_q && r_err) ? RESP_DECERR : RESP_OKAY;
    assign axi.axi_rlast   = rvalid_q & r_last;

    // ---------------- RAM ----------------
    // Read and write in one process: a same-address collision reads old data.
    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rd_en)
            rd_word <= mem[r_idx];
        for (int b = 0; b < STRB_W; b++) begin
            if (mem_we && axi.axi_wstrb[b])
                mem[w_idx][b*8 +: 8] <= axi.axi_wdata[b*8 +: 8];
        end
    end

    logic unused_ok;
    assign unused_ok = ^{axi.axi_awsize, axi.axi_awburst, axi.axi_awlock,
                         axi.axi_awcache, axi.axi_awprot, axi.axi_awqos,
                         axi.axi_arsize, axi.axi_arburst, axi.axi_arlock,
                         axi.axi_arcache, axi.axi_arprot, axi.axi_arqos,
                         axi.axi_wid, axi.axi_awaddr[OFF-1:0],
                         axi.axi_araddr[OFF-1:0]};
endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed self-checking bench for axi4_mem_slave.
// Drives bursts through the interface and compares against hand-computed values.
module tb_axi4_mem_slave;
    localparam int TMO = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_mem_slave_if #(
        .AXI_ID_WIDTH(6), .AXI_LEN_WIDTH(4),
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64)
    ) axi ();

    axi4_mem_slave #(
        .AXI_ID_WIDTH(6), .AXI_LEN_WIDTH(4), .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(64), .MEM_AWIDTH(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .axi(axi)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] wbuf [16];
    logic [63:0] rd_data [16];
    logic        rd_last [16];
    int          rd_cyc [16];
    logic [1:0]  rd_resp [16];
    logic [5:0]  rd_id [16];
    int          rd_n;
    int          stall_bad;
    logic        rd_arready_after;
    logic [1:0]  wr_resp;
    logic [5:0]  wr_id;
    int          wr_wlat, wr_blat, wr_aw_back;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_bus();
        axi.axi_awid = '0; axi.axi_awaddr = '0; axi.axi_awlen = '0;
        axi.axi_awsize = 3'd3; axi.axi_awburst = 2'b01; axi.axi_awlock = '0;
        axi.axi_awcache = '0; axi.axi_awprot = '0; axi.axi_awqos = '0;
        axi.axi_awvalid = 1'b0;
        axi.axi_wid = '0; axi.axi_wdata = '0; axi.axi_wstrb = '0;
        axi.axi_wlast = 1'b0; axi.axi_wvalid = 1'b0; axi.axi_bready = 1'b0;
        axi.axi_arid = '0; axi.axi_araddr = '0; axi.axi_arlen = '0;
        axi.axi_arsize = 3'd3; axi.axi_arburst = 2'b01; axi.axi_arlock = '0;
        axi.axi_arcache = '0; axi.axi_arprot = '0; axi.axi_arqos = '0;
        axi.axi_arvalid = 1'b0; axi.axi_rready = 1'b0;
    endtask

    // Drives one write burst from wbuf; wlast on beat nbeats-1.
    task automatic axi_write(input logic [31:0] addr, input logic [5:0] id,
                             input logic [3:0] len, input int nbeats,
                             input logic [7:0] strb);
        int t;
        axi.axi_awaddr = addr; axi.axi_awid = id; axi.axi_awlen = len;
        axi.axi_awvalid = 1'b1;
        t = 0;
        while (!axi.axi_awready && t < TMO) begin step(); t++; end
        if (t >= TMO) begin
            n_cmp++; n_bad++; $display("FAIL aw_wait: awready never seen");
        end
        step();
        axi.axi_awvalid = 1'b0;
        t = 0;
        while (!axi.axi_wready && t < TMO) begin step(); t++; end
        wr_wlat = t + 1;
        for (int i = 0; i < nbeats; i++) begin
            axi.axi_wdata = wbuf[i]; axi.axi_wstrb = strb;
            axi.axi_wlast = (i == nbeats - 1); axi.axi_wvalid = 1'b1;
            t = 0;
            while (!axi.axi_wready && t < TMO) begin step(); t++; end
            if (t >= TMO) begin
                n_cmp++; n_bad++; $display("FAIL w_wait: wready never seen");
            end
            step();
        end
        axi.axi_wvalid = 1'b0; axi.axi_wlast = 1'b0;
        t = 0;
        while (!axi.axi_bvalid && t < TMO) begin step(); t++; end
        if (t >= TMO) begin
            n_cmp++; n_bad++; $display("FAIL b_wait: bvalid never seen");
        end
        wr_blat = t + 1;
        wr_resp = axi.axi_bresp; wr_id = axi.axi_bid;
        axi.axi_bready = 1'b1;
        step();
        axi.axi_bready = 1'b0;
        t = 1;
        while (!axi.axi_awready && t < TMO) begin step(); t++; end
        wr_aw_back = t;
    endtask

    // Runs one read burst; records beats and the cycle (after AR) each was taken.
    task automatic axi_read(input logic [31:0] addr, input logic [5:0] id,
                            input logic [3:0] len, input bit toggle);
        int t, cyc;
        logic [63:0] held;
        bit hv;
        axi.axi_araddr = addr; axi.axi_arid = id; axi.axi_arlen = len;
        axi.axi_arvalid = 1'b1;
        t = 0;
        while (!axi.axi_arready && t < TMO) begin step(); t++; end
        if (t >= TMO) begin
            n_cmp++; n_bad++; $display("FAIL ar_wait: arready never seen");
        end
        step();
        axi.axi_arvalid = 1'b0;
        cyc = 1; rd_n = 0; stall_bad = 0; hv = 0; held = '0;
        while (rd_n <= int'(len) && cyc < TMO) begin
            axi.axi_rready = toggle ? cyc[0] : 1'b1;
            if (hv && axi.axi_rvalid && axi.axi_rdata !== held) stall_bad++;
            if (axi.axi_rvalid && axi.axi_rready) begin
                rd_data[rd_n] = axi.axi_rdata; rd_last[rd_n] = axi.axi_rlast;
                rd_cyc[rd_n] = cyc; rd_resp[rd_n] = axi.axi_rresp;
                rd_id[rd_n] = axi.axi_rid;
                rd_n++; hv = 0;
            end else if (axi.axi_rvalid) begin
                held = axi.axi_rdata; hv = 1;
            end
            step();
            cyc++;
        end
        axi.axi_rready = 1'b0;
        if (cyc >= TMO) begin
            n_cmp++; n_bad++; $display("FAIL r_wait: burst incomplete, %0d beats", rd_n);
        end
        rd_arready_after = axi.axi_arready;
    endtask

    task automatic test_reset();
        init_bus();
        rst_n = 1'b0;
        step(); step();
        n_cmp++;
        if ({axi.axi_awready, axi.axi_arready, axi.axi_wready} !== 3'b000) begin
            n_bad++; $display("FAIL rst_ready: got %b want 000",
                {axi.axi_awready, axi.axi_arready, axi.axi_wready});
        end
        n_cmp++;
        if ({axi.axi_bvalid, axi.axi_rvalid, axi.axi_rlast} !== 3'b000) begin
            n_bad++; $display("FAIL rst_valid: got %b want 000",
                {axi.axi_bvalid, axi.axi_rvalid, axi.axi_rlast});
        end
        n_cmp++;
        if (axi.axi_rdata !== 64'h0) begin
            n_bad++; $display("FAIL rst_rdata: got %h want 0", axi.axi_rdata);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({axi.axi_awready, axi.axi_arready} !== 2'b11) begin
            n_bad++; $display("FAIL rst_release: aw/ar ready got %b want 11",
                {axi.axi_awready, axi.axi_arready});
        end
        n_cmp++;
        if ({axi.axi_wready, axi.axi_bvalid, axi.axi_rvalid} !== 3'b000) begin
            n_bad++; $display("FAIL rst_release_idle: got %b want 000",
                {axi.axi_wready, axi.axi_bvalid, axi.axi_rvalid});
        end
    endtask

    task automatic test_write_read();
        logic [3:0] lastv;
        wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
        axi_write(32'h100, 6'd5, 4'd3, 4, 8'hFF);
        n_cmp++;
        if (wr_resp !== 2'b00) begin
            n_bad++; $display("FAIL wr_bresp: got %b want 00", wr_resp);
        end
        n_cmp++;
        if (wr_id !== 6'd5) begin
            n_bad++; $display("FAIL wr_bid: got %0d want 5", wr_id);
        end
        n_cmp++;
        if (wr_wlat !== 1) begin
            n_bad++; $display("FAIL wr_wready_lat: got %0d want 1", wr_wlat);
        end
        n_cmp++;
        if (wr_blat !== 1) begin
            n_bad++; $display("FAIL wr_bvalid_lat: got %0d want 1", wr_blat);
        end
        n_cmp++;
        if (wr_aw_back !== 2) begin
            n_bad++; $display("FAIL wr_awready_back: got %0d want 2", wr_aw_back);
        end
        axi_read(32'h100, 6'd9, 4'd3, 1'b0);
        n_cmp++;
        if (rd_n !== 4) begin
            n_bad++; $display("FAIL rd_beats: got %0d want 4", rd_n);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_data[i] !== wbuf[i] || rd_cyc[i] !== i + 2) begin
                n_bad++; $display("FAIL rd_beat%0d: got %h@%0d want %h@%0d",
                    i, rd_data[i], rd_cyc[i], wbuf[i], i + 2);
            end
        end
        lastv = {rd_last[3], rd_last[2], rd_last[1], rd_last[0]};
        n_cmp++;
        if (lastv !== 4'b1000) begin
            n_bad++; $display("FAIL rd_rlast: got %b want 1000", lastv);
        end
        n_cmp++;
        if (rd_id[0] !== 6'd9 || rd_resp[0] !== 2'b00) begin
            n_bad++; $display("FAIL rd_id_resp: got %0d/%b want 9/00", rd_id[0], rd_resp[0]);
        end
        n_cmp++;
        if (rd_arready_after !== 1'b1) begin
            n_bad++; $display("FAIL rd_arready_back: got %b want 1", rd_arready_after);
        end
    endtask

    task automatic test_strobe();
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        axi_write(32'h0, 6'd1, 4'd0, 1, 8'hFF);
        wbuf[0] = 64'h0;
        axi_write(32'h0, 6'd2, 4'd0, 1, 8'h0F);
        axi_read(32'h0, 6'd3, 4'd0, 1'b0);
        n_cmp++;
        if (rd_data[0] !== 64'hFFFF_FFFF_0000_0000) begin
            n_bad++; $display("FAIL strobe: got %h want ffffffff00000000", rd_data[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] lastv;
        for (int i = 0; i < 16; i++) wbuf[i] = 64'h1111_1111_1111_1111 * (i + 1);
        axi_write(32'h200, 6'd4, 4'd15, 16, 8'hFF);
        axi_read(32'h200, 6'd6, 4'd15, 1'b1);
        n_cmp++;
        if (rd_n !== 16) begin
            n_bad++; $display("FAIL bp_beats: got %0d want 16", rd_n);
        end
        lastv = '0;
        for (int i = 0; i < 16; i++) begin
            lastv[i] = rd_last[i];
            n_cmp++;
            if (rd_data[i] !== 64'h1111_1111_1111_1111 * (i + 1)) begin
                n_bad++; $display("FAIL bp_beat%0d: got %h want %h",
                    i, rd_data[i], 64'h1111_1111_1111_1111 * (i + 1));
            end
        end
        n_cmp++;
        if (stall_bad !== 0) begin
            n_bad++; $display("FAIL bp_stable: %0d changes while stalled, want 0", stall_bad);
        end
        n_cmp++;
        if (lastv !== 16'h8000) begin
            n_bad++; $display("FAIL bp_rlast: got %h want 8000", lastv);
        end
    endtask

    task automatic test_concurrent();
        for (int i = 0; i < 4; i++) wbuf[i] = 64'hA0 + i;
        axi_write(32'h0, 6'd1, 4'd3, 4, 8'hFF);
        for (int i = 0; i < 4; i++) wbuf[i] = 64'hB0 + i;
        fork
            axi_write(32'h800, 6'd12, 4'd3, 4, 8'hFF);
            axi_read(32'h0, 6'd13, 4'd3, 1'b0);
        join
        n_cmp++;
        if (wr_resp !== 2'b00 || wr_id !== 6'd12) begin
            n_bad++; $display("FAIL cc_b: got %b/%0d want 00/12", wr_resp, wr_id);
        end
        n_cmp++;
        if (rd_n !== 4 || rd_cyc[0] !== 2 || rd_cyc[3] !== 5) begin
            n_bad++; $display("FAIL cc_rd_timing: got %0d beats first@%0d last@%0d want 4/2/5",
                rd_n, rd_cyc[0], rd_cyc[3]);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_data[i] !== 64'hA0 + i) begin
                n_bad++; $display("FAIL cc_rd%0d: got %h want %h", i, rd_data[i], 64'hA0 + i);
            end
        end
        axi_read(32'h800, 6'd14, 4'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_data[i] !== 64'hB0 + i) begin
                n_bad++; $display("FAIL cc_wr%0d: got %h want %h", i, rd_data[i], 64'hB0 + i);
            end
        end
    endtask

    task automatic test_errors();
        wbuf[0] = 64'hDEAD_BEEF_DEAD_BEEF;
        axi_write(32'h0010_0000, 6'd20, 4'd0, 1, 8'hFF);
        n_cmp++;
        if (wr_resp !== 2'b11) begin
            n_bad++; $display("FAIL decerr_bresp: got %b want 11", wr_resp);
        end
        axi_read(32'h0, 6'd21, 4'd0, 1'b0);
        n_cmp++;
        if (rd_data[0] !== 64'hA0) begin
            n_bad++; $display("FAIL decerr_nowrite: got %h want a0", rd_data[0]);
        end
        axi_read(32'h0010_0000, 6'd22, 4'd1, 1'b0);
        n_cmp++;
        if (rd_resp[0] !== 2'b11 || rd_resp[1] !== 2'b11) begin
            n_bad++; $display("FAIL decerr_rresp: got %b,%b want 11,11", rd_resp[0], rd_resp[1]);
        end
        n_cmp++;
        if (rd_data[0] !== 64'h0 || rd_data[1] !== 64'h0 || rd_last[1] !== 1'b1) begin
            n_bad++; $display("FAIL decerr_rdata: got %h,%h last %b want 0,0 last 1",
                rd_data[0], rd_data[1], rd_last[1]);
        end
        wbuf[0] = 64'h51; wbuf[1] = 64'h52;
        axi_write(32'h300, 6'd23, 4'd3, 2, 8'hFF);
        n_cmp++;
        if (wr_resp !== 2'b10) begin
            n_bad++; $display("FAIL early_wlast_bresp: got %b want 10", wr_resp);
        end
        n_cmp++;
        if (wr_aw_back !== 2) begin
            n_bad++; $display("FAIL early_wlast_idle: awready after %0d want 2", wr_aw_back);
        end
        wbuf[0] = 64'h60;
        axi_write(32'h300, 6'd24, 4'd0, 1, 8'hFF);
        n_cmp++;
        if (wr_resp !== 2'b00) begin
            n_bad++; $display("FAIL after_slverr_bresp: got %b want 00", wr_resp);
        end
        wbuf[0] = 64'hC0; wbuf[1] = 64'hC1;
        axi_write(32'h1FF8, 6'd25, 4'd1, 2, 8'hFF);
        axi_read(32'h1FF8, 6'd26, 4'd1, 1'b0);
        n_cmp++;
        if (rd_data[0] !== 64'hC0 || rd_data[1] !== 64'hC1) begin
            n_bad++; $display("FAIL wrap_read: got %h,%h want c0,c1", rd_data[0], rd_data[1]);
        end
        axi_read(32'h0, 6'd27, 4'd0, 1'b0);
        n_cmp++;
        if (rd_data[0] !== 64'hC1) begin
            n_bad++; $display("FAIL wrap_word0: got %h want c1", rd_data[0]);
        end
    endtask

    task automatic test_reset_mid_read();
        int t;
        axi.axi_araddr = 32'h200; axi.axi_arid = 6'd30; axi.axi_arlen = 4'd15;
        axi.axi_arvalid = 1'b1; axi.axi_rready = 1'b1;
        t = 0;
        while (!axi.axi_arready && t < TMO) begin step(); t++; end
        step();
        axi.axi_arvalid = 1'b0;
        step(); step(); step();
        n_cmp++;
        if (axi.axi_rvalid !== 1'b1 || axi.axi_rdata !== 64'h3333_3333_3333_3333) begin
            n_bad++; $display("FAIL mid_beat2: got %b/%h want 1/3333333333333333",
                axi.axi_rvalid, axi.axi_rdata);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({axi.axi_rvalid, axi.axi_rlast, axi.axi_arready} !== 3'b000) begin
            n_bad++; $display("FAIL mid_rst_abort: got %b want 000",
                {axi.axi_rvalid, axi.axi_rlast, axi.axi_arready});
        end
        step(); step();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({axi.axi_arready, axi.axi_awready} !== 2'b11) begin
            n_bad++; $display("FAIL mid_rst_release: got %b want 11",
                {axi.axi_arready, axi.axi_awready});
        end
        step(); step();
        n_cmp++;
        if ({axi.axi_rvalid, axi.axi_bvalid} !== 2'b00) begin
            n_bad++; $display("FAIL mid_rst_quiet: got %b want 00",
                {axi.axi_rvalid, axi.axi_bvalid});
        end
        axi.axi_rready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_backpressure();
        test_concurrent();
        test_errors();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
